// File: rtl/intc_pkg.sv
// Shared definitions for the nested interrupt controller: parameter defaults,
// EPC stack command encoding, nesting modes and the request priority encoder.
package intc_pkg;

  localparam int          NUM_IRQ_DEF    = 3;
  localparam int          DEPTH_DEF      = 4;
  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_3000;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0100;

  localparam logic EPC_PUSH = 1'b0;
  localparam logic EPC_POP  = 1'b1;

  typedef enum logic [1:0] {
    MODE_IDLE    = 2'd0,
    MODE_SERVICE = 2'd1,
    MODE_FULL    = 2'd2
  } mode_e;

  // Highest set bit index wins; returns 0 for an empty vector.
  function automatic int prio_enc(input logic [31:0] req);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (req[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge capture of the raw request lines into sticky pending bits,
// cleared per line by the controller when that request is taken.
module irq_edge_latch
  import intc_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] clr,
  output logic [NUM_IRQ-1:0] pending
);

  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] rise;

  // A fresh edge wins over the clear so a re-request during take is kept.
  always_comb begin
    rise       = irq & ~irq_prev_q;
    pending_d  = (pending_q & ~clr) | rise;
    irq_prev_d = irq;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/int_nest_ctrl.sv
// Nested interrupt controller driving the EPC stack push/pop and handler PC.
// Optional sticky error output enabled by defining INTC_ERR_EN.
module int_nest_ctrl
  import intc_pkg::*;
#(
  parameter int          NUM_IRQ    = NUM_IRQ_DEF,
  parameter int          DEPTH      = DEPTH_DEF,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_IRQ-1:0]         irq,
  input  logic                       ie,
  input  logic                       eret,
  input  logic                       stall,
  input  logic [31:0]                ret_pc,
  output logic                       int_take,
  output logic [31:0]                handler_addr,
  output logic                       epc_en,
  output logic                       epc_sel,
  output logic [31:0]                epc_data,
  output logic [NUM_IRQ-1:0]         pending,
  output logic [$clog2(DEPTH+1)-1:0] nest
`ifdef INTC_ERR_EN
  , output logic                     err
`endif
);

  localparam int IDX_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int NEST_W = $clog2(DEPTH+1);

  logic [NUM_IRQ-1:0] pending_w, take_mask;
  logic [IDX_W-1:0]   lvl_q [DEPTH];
  logic [IDX_W-1:0]   lvl_d [DEPTH];
  logic [NEST_W-1:0]  nest_q, nest_d;
  logic [IDX_W-1:0]   p, top;
  logic               preempt, req, take, pop;
  mode_e              mode;

  irq_edge_latch #(.NUM_IRQ(NUM_IRQ)) u_latch (
    .clk     (clk),
    .rst     (rst),
    .irq     (irq),
    .clr     (take_mask),
    .pending (pending_w)
  );

  // An empty level stack behaves as priority -1, so anything pre-empts it.
  always_comb begin
    p   = IDX_W'(prio_enc(32'(pending_w)));
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (nest_q == NEST_W'(i + 1)) top = lvl_q[i];
    end
    if (nest_q == '0)                  mode = MODE_IDLE;
    else if (nest_q == NEST_W'(DEPTH)) mode = MODE_FULL;
    else                               mode = MODE_SERVICE;
    preempt   = (mode == MODE_IDLE) || (p > top);
    req       = rst && ie && !stall && !eret && (|pending_w) && preempt;
    take      = req && (mode != MODE_FULL);
    pop       = rst && eret && (mode != MODE_IDLE);
    take_mask = take ? (NUM_IRQ'(1) << p) : '0;
  end

  always_comb begin
    nest_d = nest_q;
    lvl_d  = lvl_q;
    if (pop) begin
      nest_d = nest_q - NEST_W'(1);
    end else if (take) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (nest_q == NEST_W'(i)) lvl_d[i] = p;
      end
      nest_d = nest_q + NEST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      nest_q <= '0;
      for (int i = 0; i < DEPTH; i++) lvl_q[i] <= '0;
    end else begin
      nest_q <= nest_d;
      lvl_q  <= lvl_d;
    end
  end

  assign int_take     = take;
  assign handler_addr = take ? (VEC_BASE + 32'(p) * VEC_STRIDE) : 32'h0;
  assign epc_en       = take | pop;
  assign epc_sel      = pop ? EPC_POP : EPC_PUSH;
  assign epc_data     = take ? ret_pc : 32'h0;
  assign pending      = pending_w;
  assign nest         = nest_q;

`ifdef INTC_ERR_EN
  logic err_q, err_d;

  // Sticky: stray eret, or a request that would pre-empt but the stack is full.
  always_comb begin
    err_d = err_q | (rst && eret && (mode == MODE_IDLE)) | (req && (mode == MODE_FULL));
  end

  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_int_nest_ctrl.sv
// Scoreboard bench for int_nest_ctrl: directed stimulus queues expected EPC
// events; a monitor matches them against the DUT cycle by cycle.
module tb_int_nest_ctrl;

  localparam int NI = 5;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] irq;
  logic          ie, eret, stall;
  logic [31:0]   ret_pc;
  logic          int_take, epc_en, epc_sel;
  logic [31:0]   handler_addr, epc_data;
  logic [NI-1:0] pending;
  logic [2:0]    nest;
`ifdef INTC_ERR_EN
  logic          err;
`endif

  int_nest_ctrl #(.NUM_IRQ(NI), .DEPTH(DP)) dut (
    .clk          (clk),
    .rst          (rst),
    .irq          (irq),
    .ie           (ie),
    .eret         (eret),
    .stall        (stall),
    .ret_pc       (ret_pc),
    .int_take     (int_take),
    .handler_addr (handler_addr),
    .epc_en       (epc_en),
    .epc_sel      (epc_sel),
    .epc_data     (epc_data),
    .pending      (pending),
    .nest         (nest)
`ifdef INTC_ERR_EN
    , .err        (err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        sel;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_take(int c, int idx, logic [31:0] pc);
    ev_t e;
    e.cyc  = c;
    e.sel  = 1'b0;
    e.addr = 32'h3000 + 32'(idx) * 32'h100;
    e.data = pc;
    exp_q.push_back(e);
  endtask

  task automatic exp_pop(int c);
    ev_t e;
    e.cyc  = c;
    e.sel  = 1'b1;
    e.addr = 32'h0;
    e.data = 32'h0;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        tests++;
        fails++;
        $display("FAIL missed_epc_event: nothing at cycle %0d, required sel=%0b addr=%0h data=%0h",
                 e.cyc, e.sel, e.addr, e.data);
      end
      if (epc_en) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_epc_event: cycle %0d sel=%0b take=%0b addr=%0h data=%0h, required none",
                   cyc, epc_sel, int_take, handler_addr, epc_data);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || epc_sel !== e.sel || int_take !== ~e.sel ||
              handler_addr !== e.addr || epc_data !== e.data) begin
            fails++;
            $display("FAIL epc_event: cycle %0d sel=%0b take=%0b addr=%0h data=%0h, required cycle %0d sel=%0b addr=%0h data=%0h",
                     cyc, epc_sel, int_take, handler_addr, epc_data, e.cyc, e.sel, e.addr, e.data);
          end
        end
      end else if (int_take || epc_sel || handler_addr != 32'h0 || epc_data != 32'h0) begin
        tests++;
        fails++;
        $display("FAIL idle_outputs: cycle %0d take=%0b sel=%0b addr=%0h data=%0h, required all 0",
                 cyc, int_take, epc_sel, handler_addr, epc_data);
      end
    end
  endtask

  int c;

  initial begin
    rst = 1'b0; irq = '0; ie = 1'b1; eret = 1'b0; stall = 1'b0; ret_pc = 32'h0;
    fork
      monitor();
    join_none
    repeat (3) tick();
    rst = 1'b1;
    chk("reset_nest", 32'(nest), 32'h0);
    chk("reset_pending", 32'(pending), 32'h0);
`ifdef INTC_ERR_EN
    chk("reset_err", 32'(err), 32'h0);
`endif
    tick(); tick();

    // Single request on irq0
    c = cyc; irq = 5'b00001; ret_pc = 32'h40; exp_take(c + 1, 0, 32'h40);
    tick(); irq = '0;
    chk("t1_pending_latched", 32'(pending), 32'h1);
    tick();
    chk("t1_nest", 32'(nest), 32'h1);
    chk("t1_pending_cleared", 32'(pending), 32'h0);

    // Nesting: irq2 pre-empts, irq1 waits until pop
    c = cyc; irq = 5'b00100; ret_pc = 32'h44; exp_take(c + 1, 2, 32'h44);
    tick(); irq = '0;
    tick();
    chk("t2_nest2", 32'(nest), 32'h2);
    irq = 5'b00010;
    tick(); irq = '0;
    chk("t2_irq1_pending", 32'(pending), 32'h2);
    tick();
    chk("t2_irq1_blocked", 32'(pending), 32'h2);
    chk("t2_nest_held", 32'(nest), 32'h2);
    eret = 1'b1; exp_pop(cyc);
    tick(); eret = 1'b0; ret_pc = 32'h48; exp_take(cyc, 1, 32'h48);
    chk("t2_nest_after_pop", 32'(nest), 32'h1);
    tick();
    chk("t2_nest_irq1", 32'(nest), 32'h2);
    chk("t2_pending_empty", 32'(pending), 32'h0);
    eret = 1'b1; exp_pop(cyc);
    tick(); exp_pop(cyc);
    tick(); eret = 1'b0;
    chk("t2_unwound", 32'(nest), 32'h0);

    // Simultaneous irq1/irq0 and eret precedence over a take
    c = cyc; irq = 5'b00011; ret_pc = 32'h50; exp_take(c + 1, 1, 32'h50);
    tick(); irq = '0;
    tick();
    chk("t3_irq0_waits", 32'(pending), 32'h1);
    chk("t3_nest1", 32'(nest), 32'h1);
    eret = 1'b1; exp_pop(cyc);
    tick(); eret = 1'b0; ret_pc = 32'h54; exp_take(cyc, 0, 32'h54);
    tick();
    chk("t3_irq0_in_service", 32'(nest), 32'h1);
    irq = 5'b00100;
    tick(); irq = '0; eret = 1'b1; exp_pop(cyc);
    chk("t3_irq2_pending", 32'(pending), 32'h4);
    tick(); eret = 1'b0;
    chk("t3_pop_only_nest", 32'(nest), 32'h0);
    chk("t3_irq2_still_pending", 32'(pending), 32'h4);
    ret_pc = 32'h58; exp_take(cyc, 2, 32'h58);
    tick();
    chk("t3_irq2_taken", 32'(nest), 32'h1);
    eret = 1'b1; exp_pop(cyc);
    tick(); eret = 1'b0;
    chk("t3_unwound", 32'(nest), 32'h0);

    // Full stack: ladder irq0..irq3, irq4 blocked until one pop
    ret_pc = 32'h60;
    c = cyc; irq = 5'b00001; exp_take(c + 1, 0, 32'h60);
    tick(); irq = 5'b00010; exp_take(cyc + 1, 1, 32'h60);
    tick(); irq = 5'b00100; exp_take(cyc + 1, 2, 32'h60);
    tick(); irq = 5'b01000; exp_take(cyc + 1, 3, 32'h60);
    tick(); irq = '0;
    tick();
    chk("t4_full", 32'(nest), 32'h4);
    irq = 5'b10000;
    tick(); irq = '0;
    chk("t4_irq4_pending", 32'(pending), 32'h10);
    tick();
    chk("t4_irq4_blocked", 32'(pending), 32'h10);
    chk("t4_still_full", 32'(nest), 32'h4);
`ifdef INTC_ERR_EN
    chk("t4_err_full", 32'(err), 32'h1);
`endif
    eret = 1'b1; exp_pop(cyc);
    tick(); eret = 1'b0; exp_take(cyc, 4, 32'h60);
    tick();
    chk("t4_refull", 32'(nest), 32'h4);
    chk("t4_pending_empty", 32'(pending), 32'h0);
    eret = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_pop(cyc);
      tick();
    end
    eret = 1'b0;
    chk("t4_unwound", 32'(nest), 32'h0);

    // Gating by ie and stall, then stray eret
    ie = 1'b0; irq = 5'b00100;
    tick(); irq = '0;
    tick();
    chk("t5_ie_gate", 32'(pending), 32'h4);
    ie = 1'b1; stall = 1'b1;
    tick();
    chk("t5_stall_gate", 32'(pending), 32'h4);
    chk("t5_no_take_nest", 32'(nest), 32'h0);
    stall = 1'b0; ret_pc = 32'h70; exp_take(cyc, 2, 32'h70);
    tick();
    chk("t5_taken", 32'(nest), 32'h1);
    eret = 1'b1; exp_pop(cyc);
    tick();
    chk("t5_popped", 32'(nest), 32'h0);
    tick(); eret = 1'b0;
    chk("t5_stray_eret", 32'(nest), 32'h0);

    // Reset in the middle of nested service
    ret_pc = 32'h80;
    c = cyc; irq = 5'b00010; exp_take(c + 1, 1, 32'h80);
    tick(); irq = 5'b00100; exp_take(cyc + 1, 2, 32'h80);
    tick(); irq = 5'b00001;
    tick(); irq = '0;
    chk("t6_nest2", 32'(nest), 32'h2);
    chk("t6_pending", 32'(pending), 32'h1);
    rst = 1'b0; eret = 1'b1;
    tick(); rst = 1'b1; eret = 1'b0;
    chk("t6_nest_reset", 32'(nest), 32'h0);
    chk("t6_pending_reset", 32'(pending), 32'h0);
    chk("t6_epc_en", 32'(epc_en), 32'h0);
    chk("t6_handler", handler_addr, 32'h0);
`ifdef INTC_ERR_EN
    chk("t6_err_reset", 32'(err), 32'h0);
`endif

    tick(); tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
